// File: rtl/gene_net_pkg.sv
// gene_net_pkg: shared constants and types for the gene network attractor search.
//   STATE_W_DEF : default width of the network state vector
//   state_e     : search FSM encoding (IDLE, RUN, MEASURE, DONE)
//   result_e    : kind of attractor found (none / fixed point / cycle)
package gene_net_pkg;

    localparam int STATE_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_FIXED = 2'd1,
        RES_CYCLE = 2'd2
    } result_e;

endpackage

// File: rtl/visited_bitmap.sv
// visited_bitmap: one bit per network state, recording states already seen
// on the current trajectory.
//   clk, rst_n : clock, async active-low reset (clears all bits)
//   clr_i      : clear every bit this edge (wins over set)
//   set_i      : mark set_idx_i visited this edge
//   set_idx_i  : state to mark
//   qry_idx_i  : state to look up
//   hit_o      : combinational: qry_idx_i has been visited
module visited_bitmap #(
    parameter int STATE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               set_i,
    input  logic [STATE_W-1:0] set_idx_i,
    input  logic [STATE_W-1:0] qry_idx_i,
    output logic               hit_o
);

    localparam int DEPTH = 1 << STATE_W;

    logic [DEPTH-1:0] bits_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= '0;
        end else if (clr_i) begin
            bits_q <= '0;
        end else if (set_i) begin
            bits_q[set_idx_i] <= 1'b1;
        end
    end

    assign hit_o = bits_q[qry_idx_i];

endmodule

// File: rtl/attractor_detector.sv
// attractor_detector: walks a gene network trajectory from init_val, one
// state per cycle, until it revisits a state, then measures the attractor.
//   clk, rst_n    : clock, async active-low reset
//   start         : (re)start a search from init_val, any state
//   init_val      : initial network state
//   next_state    : network response to cur_state (combinational, same cycle)
//   cur_state     : state presented to the network
//   busy / done   : search running / result valid (held until next start)
//   fixed / cycle : attractor kind, exactly one set while done
//   cycle_len     : attractor length (1 for a fixed point)
//   transient_len : states visited before entering the attractor
module attractor_detector
    import gene_net_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [STATE_W-1:0] init_val,
    input  logic [STATE_W-1:0] next_state,
    output logic [STATE_W-1:0] cur_state,
    output logic               busy,
    output logic               done,
    output logic               fixed,
    output logic               cycle,
    output logic [STATE_W:0]   cycle_len,
    output logic [STATE_W:0]   transient_len
);

    localparam int LW = STATE_W + 1;

    state_e             state_q;
    result_e            kind_q;
    logic [STATE_W-1:0] cur_q;
    logic [STATE_W-1:0] anchor_q;
    logic [LW-1:0]      steps_q;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      cyc_len_q;
    logic [LW-1:0]      trans_q;
    logic               seen;

    function automatic logic [LW-1:0] sat_sub(input logic [LW-1:0] a,
                                              input logic [LW-1:0] b);
        return (a >= b) ? (a - b) : '0;
    endfunction

    // Bitmap is cleared on the start edge, so a restart never sees stale marks.
    visited_bitmap #(.STATE_W(STATE_W)) u_visited (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (start),
        .set_i     (state_q == S_RUN),
        .set_idx_i (cur_q),
        .qry_idx_i (next_state),
        .hit_o     (seen)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            kind_q    <= RES_NONE;
            cur_q     <= '0;
            anchor_q  <= '0;
            steps_q   <= '0;
            len_q     <= '0;
            cyc_len_q <= '0;
            trans_q   <= '0;
        end else if (start) begin
            state_q   <= S_RUN;
            kind_q    <= RES_NONE;
            cur_q     <= init_val;
            steps_q   <= '0;
            len_q     <= '0;
            cyc_len_q <= '0;
            trans_q   <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    steps_q <= steps_q + 1'b1;
                    if (next_state == cur_q) begin
                        state_q   <= S_DONE;
                        kind_q    <= RES_FIXED;
                        cyc_len_q <= LW'(1);
                        // steps_q + 1 counts the detecting cycle itself
                        trans_q   <= sat_sub(steps_q + 1'b1, LW'(1));
                    end else if (seen) begin
                        // First revisited state is on the attractor; walk once round it.
                        state_q  <= S_MEASURE;
                        anchor_q <= next_state;
                        cur_q    <= next_state;
                        len_q    <= LW'(1);
                    end else begin
                        cur_q <= next_state;
                    end
                end
                S_MEASURE: begin
                    if (next_state == anchor_q) begin
                        state_q   <= S_DONE;
                        kind_q    <= RES_CYCLE;
                        cyc_len_q <= len_q;
                        // steps_q already includes the RUN cycle that detected the revisit
                        trans_q   <= sat_sub(steps_q, len_q);
                    end else begin
                        cur_q <= next_state;
                        len_q <= len_q + 1'b1;
                    end
                end
                default: ; // IDLE and DONE hold until the next start
            endcase
        end
    end

    assign cur_state     = cur_q;
    assign busy          = (state_q == S_RUN) || (state_q == S_MEASURE);
    assign done          = (state_q == S_DONE);
    assign fixed         = (kind_q == RES_FIXED);
    assign cycle         = (kind_q == RES_CYCLE);
    assign cycle_len     = cyc_len_q;
    assign transient_len = trans_q;

endmodule

// File: tb/tb_attractor_detector.sv
module tb_attractor_detector;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] init_val;
    logic [7:0] next_state;
    logic [7:0] cur_state;
    logic       busy, done, fixed, cycle;
    logic [8:0] cycle_len, transient_len;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    attractor_detector #(.STATE_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .init_val      (init_val),
        .next_state    (next_state),
        .cur_state     (cur_state),
        .busy          (busy),
        .done          (done),
        .fixed         (fixed),
        .cycle         (cycle),
        .cycle_len     (cycle_len),
        .transient_len (transient_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Network model: 0 identity, 1 low-2-bit +1 ring, 2 chain 0-1-2-3-2, 3 +1 mod 256
    always_comb begin
        next_state = cur_state;
        case (mode)
            1: next_state = {cur_state[7:2], cur_state[1:0] + 2'd1};
            2: case (cur_state)
                   8'h00: next_state = 8'h01;
                   8'h01: next_state = 8'h02;
                   8'h02: next_state = 8'h03;
                   8'h03: next_state = 8'h02;
                   default: next_state = cur_state;
               endcase
            3: next_state = cur_state + 8'd1;
            default: next_state = cur_state;
        endcase
    end

    // Pulse start for one posedge; returns at the negedge after that edge.
    task automatic do_start(input logic [7:0] v);
        @(negedge clk);
        start = 1'b1;
        init_val = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts further posedges until done; cnt = budget means timeout.
    task automatic wait_done(input int budget, output int cnt);
        cnt = 0;
        while (!done && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        init_val = 8'h00;
        #12;
        checks++;
        if ({busy, done, fixed, cycle} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {busy, done, fixed, cycle});
        end
        checks++;
        if ({cur_state, cycle_len, transient_len} !== 26'd0) begin
            failures++;
            $display("FAIL reset_values cur=%h clen=%0d tlen=%0d exp all 0", cur_state, cycle_len, transient_len);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fixed;
        int cnt;
        mode = 0;
        do_start(8'h05);
        wait_done(20, cnt);
        checks++;
        if (cnt !== 1) begin
            failures++;
            $display("FAIL fixed_latency got=%0d exp=1 edges after start edge", cnt);
        end
        checks++;
        if ({fixed, cycle, cycle_len, transient_len, cur_state} !== {1'b1, 1'b0, 9'd1, 9'd0, 8'h05}) begin
            failures++;
            $display("FAIL fixed_result fixed=%b cycle=%b clen=%0d tlen=%0d cur=%h exp 1 0 1 0 05",
                     fixed, cycle, cycle_len, transient_len, cur_state);
        end
    endtask

    task automatic test_cycle4;
        int cnt;
        mode = 1;
        do_start(8'h10);
        wait_done(50, cnt);
        checks++;
        if (cnt !== 8) begin
            failures++;
            $display("FAIL ring4_latency got=%0d exp=8", cnt);
        end
        checks++;
        if ({fixed, cycle, cycle_len, transient_len} !== {1'b0, 1'b1, 9'd4, 9'd0}) begin
            failures++;
            $display("FAIL ring4_result fixed=%b cycle=%b clen=%0d tlen=%0d exp 0 1 4 0",
                     fixed, cycle, cycle_len, transient_len);
        end
    endtask

    task automatic test_tail;
        int cnt;
        mode = 2;
        do_start(8'h00);
        wait_done(50, cnt);
        checks++;
        if (cnt !== 6) begin
            failures++;
            $display("FAIL tail_latency got=%0d exp=6", cnt);
        end
        checks++;
        if ({fixed, cycle, cycle_len, transient_len} !== {1'b0, 1'b1, 9'd2, 9'd2}) begin
            failures++;
            $display("FAIL tail_result fixed=%b cycle=%b clen=%0d tlen=%0d exp 0 1 2 2",
                     fixed, cycle, cycle_len, transient_len);
        end
    endtask

    // With start low, DONE holds every output even while the network changes.
    task automatic test_hold;
        logic [7:0] cs;
        cs = cur_state;
        mode = 3;
        repeat (5) @(negedge clk);
        checks++;
        if ({done, busy, cycle, cycle_len, transient_len, cur_state} !== {1'b1, 1'b0, 1'b1, 9'd2, 9'd2, cs}) begin
            failures++;
            $display("FAIL done_hold done=%b busy=%b cycle=%b clen=%0d tlen=%0d cur=%h exp 1 0 1 2 2 %h",
                     done, busy, cycle, cycle_len, transient_len, cur_state, cs);
        end
    endtask

    task automatic test_full256;
        int cnt;
        int busy_cnt;
        mode = 3;
        do_start(8'h00);
        busy_cnt = 1; // busy across the edge that follows the start edge onwards
        cnt = 0;
        while (!done && cnt < 700) begin
            @(negedge clk);
            cnt++;
            if (busy) busy_cnt++;
        end
        checks++;
        if (cnt !== 512) begin
            failures++;
            $display("FAIL full256_latency got=%0d exp=512", cnt);
        end
        checks++;
        if (busy_cnt > 513) begin
            failures++;
            $display("FAIL full256_busy got=%0d exp<=513", busy_cnt);
        end
        checks++;
        if ({fixed, cycle, cycle_len, transient_len} !== {1'b0, 1'b1, 9'd256, 9'd0}) begin
            failures++;
            $display("FAIL full256_result fixed=%b cycle=%b clen=%0d tlen=%0d exp 0 1 256 0",
                     fixed, cycle, cycle_len, transient_len);
        end
    endtask

    task automatic test_abort;
        int cnt;
        mode = 1;
        do_start(8'h10);
        repeat (5) @(negedge clk); // 4 RUN edges then into MEASURE
        checks++;
        if ({busy, done} !== 2'b10) begin
            failures++;
            $display("FAIL abort_pre busy=%b done=%b exp 1 0", busy, done);
        end
        mode = 0;
        do_start(8'h07);
        checks++;
        if ({busy, done, cur_state} !== {1'b1, 1'b0, 8'h07}) begin
            failures++;
            $display("FAIL abort_restart busy=%b done=%b cur=%h exp 1 0 07", busy, done, cur_state);
        end
        wait_done(20, cnt);
        checks++;
        if ({cnt[7:0], fixed, cycle, cycle_len, transient_len} !== {8'd1, 1'b1, 1'b0, 9'd1, 9'd0}) begin
            failures++;
            $display("FAIL abort_result lat=%0d fixed=%b cycle=%b clen=%0d tlen=%0d exp 1 1 0 1 0",
                     cnt, fixed, cycle, cycle_len, transient_len);
        end
    endtask

    task automatic test_reset_mid_run;
        mode = 3;
        do_start(8'h00);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, fixed, cycle, cur_state, cycle_len, transient_len} !== 30'd0) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b cur=%h clen=%0d tlen=%0d exp all 0",
                     busy, done, cur_state, cycle_len, transient_len);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({busy, done, cur_state} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_release busy=%b done=%b cur=%h exp 0 0 00", busy, done, cur_state);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_cycle4();
        test_tail();
        test_hold();
        test_full256();
        test_abort();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
